// File: rtl/fifo_rd_pkg.sv
// Shared types for the dual-clock FIFO read-side burst consumer.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } rd_state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_DW    = 8;

  typedef struct packed {
    logic [SKID_DW-1:0] data;
    logic               last;
  } skid_entry_t;

  // A new read may issue only if the word it returns is guaranteed a slot.
  function automatic logic credit_ok(input logic [1:0] occ, input logic inflight, input logic pop);
    logic [2:0] pending;
    pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return (pending < 3'd2);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry {data, last} skid buffer absorbing the FIFO's one-cycle read latency.
// The data width must match fifo_rd_pkg::SKID_DW.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = SKID_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DSIZE-1:0] push_data,
  input  logic             push_last,
  input  logic             pop,
  output logic [DSIZE-1:0] head_data,
  output logic             head_last,
  output logic             valid,
  output logic [1:0]       occ
);

  localparam logic [1:0] OCC_FULL = 2'(SKID_DEPTH);

  skid_entry_t mem_r [SKID_DEPTH];
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  occ_r;
  logic        push_s;
  logic        pop_s;
  skid_entry_t head_s;

  // Qualify push/pop against the current occupancy and select the head entry.
  always_comb begin
    pop_s  = pop && (occ_r != 2'd0);
    push_s = push && ((occ_r != OCC_FULL) || pop_s);
    head_s = mem_r[rd_ptr_r];
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_r[i] <= {(SKID_DW + 1){1'b0}};
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {push_data, push_last};
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign head_data = head_s.data;
  assign head_last = head_s.last;
  assign valid     = (occ_r != 2'd0);
  assign occ       = occ_r;

endmodule

// File: rtl/fifo_rd_burst.sv
// Read-side burst consumer: drains the FIFO in BURST_LEN-word bursts onto a valid/ready stream.
// Optional FIFO_RD_BURST_TIMEOUT_EN drains a partial fill after TIMEOUT idle cycles.
module fifo_rd_burst
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE     = SKID_DW,
  parameter int ASIZE     = 5,
  parameter int BURST_LEN = 8
`ifdef FIFO_RD_BURST_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 16
`endif
) (
  input  logic             rclk,
  input  logic             rst,
  output logic             r_en,
  input  logic             r_ok,
  input  logic [DSIZE-1:0] rdata,
  input  logic             r_empty,
  input  logic [ASIZE-1:0] ruse,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             busy,
  output logic [15:0]      burst_cnt
);

  localparam logic [ASIZE-1:0] BURST_LEN_W = ASIZE'(BURST_LEN);
  localparam logic [ASIZE-1:0] ISSUE_ONE   = ASIZE'(1);
  localparam logic [ASIZE-1:0] ISSUE_ZERO  = {ASIZE{1'b0}};

  rd_state_e        state_r;
  rd_state_e        state_nxt_s;
  logic [ASIZE-1:0] issue_cnt_r;
  logic [ASIZE-1:0] issue_cnt_nxt_s;
  logic             inflight_r;
  logic             inflight_last_r;
  logic [15:0]      burst_cnt_r;
  logic             burst_done_s;
  logic             r_en_s;
  logic             push_s;
  logic             pop_s;
  logic             start_part_s;
  logic [1:0]       occ_s;
  logic             skid_valid_s;
  logic [DSIZE-1:0] head_data_s;
  logic             head_last_s;

  assign pop_s  = skid_valid_s && m_ready;
  assign push_s = r_ok && inflight_r;
  assign r_en_s = (state_r == ST_BURST) && !r_empty && (issue_cnt_r != ISSUE_ZERO) &&
                  credit_ok(occ_s, inflight_r, pop_s);

`ifdef FIFO_RD_BURST_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  logic [15:0] idle_cnt_r;
  logic        partial_s;

  assign partial_s    = (state_r == ST_IDLE) && (ruse != ISSUE_ZERO) && (ruse < BURST_LEN_W);
  assign start_part_s = partial_s && (idle_cnt_r == TIMEOUT_LAST);

  // Idle counter: runs only while a partial fill sits in the FIFO.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      idle_cnt_r <= 16'd0;
    end else if (partial_s && !start_part_s) begin
      idle_cnt_r <= idle_cnt_r + 16'd1;
    end else begin
      idle_cnt_r <= 16'd0;
    end
  end
`else
  assign start_part_s = 1'b0;
`endif

  // Next-state and issue-counter logic.
  always_comb begin
    state_nxt_s     = state_r;
    issue_cnt_nxt_s = issue_cnt_r;
    burst_done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ruse >= BURST_LEN_W) begin
          state_nxt_s     = ST_BURST;
          issue_cnt_nxt_s = BURST_LEN_W;
        end else if (start_part_s) begin
          state_nxt_s     = ST_BURST;
          issue_cnt_nxt_s = ruse;
        end else begin
          state_nxt_s     = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (r_en_s) begin
          issue_cnt_nxt_s = issue_cnt_r - ISSUE_ONE;
          state_nxt_s     = (issue_cnt_r == ISSUE_ONE) ? ST_FLUSH : ST_BURST;
        end else if (issue_cnt_r == ISSUE_ZERO) begin
          state_nxt_s     = ST_FLUSH;
        end else begin
          state_nxt_s     = ST_BURST;
        end
      end
      ST_FLUSH: begin
        if (!inflight_r) begin
          state_nxt_s  = ST_IDLE;
          burst_done_s = 1'b1;
        end else begin
          state_nxt_s  = ST_FLUSH;
        end
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        issue_cnt_nxt_s = ISSUE_ZERO;
      end
    endcase
  end

  // State, in-flight tracking and burst counter.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      issue_cnt_r     <= ISSUE_ZERO;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      burst_cnt_r     <= 16'd0;
    end else begin
      state_r         <= state_nxt_s;
      issue_cnt_r     <= issue_cnt_nxt_s;
      inflight_r      <= r_en_s;
      inflight_last_r <= r_en_s && (issue_cnt_r == ISSUE_ONE);
      if (burst_done_s) begin
        burst_cnt_r <= burst_cnt_r + 16'd1;
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end
    end
  end

  fifo_rd_skid #(
    .DSIZE (DSIZE)
  ) u_skid (
    .clk       (rclk),
    .rst       (rst),
    .push      (push_s),
    .push_data (rdata),
    .push_last (inflight_last_r),
    .pop       (pop_s),
    .head_data (head_data_s),
    .head_last (head_last_s),
    .valid     (skid_valid_s),
    .occ       (occ_s)
  );

  assign r_en      = r_en_s;
  assign m_valid   = skid_valid_s;
  assign m_data    = head_data_s;
  assign m_last    = head_last_s && skid_valid_s;
  assign busy      = (state_r != ST_IDLE);
  assign burst_cnt = burst_cnt_r;

endmodule

// File: tb/tb_fifo_rd_burst.sv
// Directed self-checking bench for fifo_rd_burst with a cycle-level FIFO read-port model.
module tb_fifo_rd_burst;

  logic        rclk;
  logic        rst;
  logic        r_en;
  logic        r_ok;
  logic [7:0]  rdata;
  logic        r_empty;
  logic [4:0]  ruse;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic [15:0] burst_cnt;

  fifo_rd_burst #(
    .DSIZE     (8),
    .ASIZE     (5),
    .BURST_LEN (8)
  ) u_dut (
    .rclk      (rclk),
    .rst       (rst),
    .r_en      (r_en),
    .r_ok      (r_ok),
    .rdata     (rdata),
    .r_empty   (r_empty),
    .ruse      (ruse),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .busy      (busy),
    .burst_cnt (burst_cnt)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int vec  = 0;
  int miss = 0;

  logic [7:0] mem [0:63];
  int wr_idx = 0;
  int rd_idx = 0;
  logic force_empty = 1'b0;

  int cyc = 0;
  int fires = 0;
  int outs = 0;
  int max_out = 0;
  int empty_viol = 0;
  int busy_cyc = 0;
  logic last_ren = 1'b0;
  int         ren_cyc [$];
  int         out_cyc [$];
  logic [7:0] out_data [$];
  logic       out_last [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd_fifo();
    r_empty = ((wr_idx - rd_idx) == 0) || force_empty;
    ruse    = 5'(wr_idx - rd_idx);
  endtask

  task automatic load(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_idx] = base + 8'(i);
      wr_idx++;
    end
    upd_fifo();
  endtask

  task automatic clear_logs();
    ren_cyc.delete();
    out_cyc.delete();
    out_data.delete();
    out_last.delete();
  endtask

  // One clock: observe at the falling edge, update the FIFO model 1 time unit after the rising edge.
  task automatic step();
    logic fire;
    logic xfer;
    @(negedge rclk);
    cyc++;
    fire     = r_en;
    last_ren = r_en;
    xfer     = m_valid && m_ready;
    if (fire) ren_cyc.push_back(cyc);
    if (fire && force_empty) empty_viol++;
    if (busy) busy_cyc++;
    if (xfer) begin
      out_cyc.push_back(cyc);
      out_data.push_back(m_data);
      out_last.push_back(m_last);
    end
    @(posedge rclk);
    #1;
    if (fire) fires++;
    if (xfer) outs++;
    if (fires - outs > max_out) max_out = fires - outs;
    if (fire) begin
      r_ok  = 1'b1;
      rdata = mem[rd_idx];
      rd_idx++;
    end else begin
      r_ok  = 1'b0;
    end
    upd_fifo();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_burst(input string name, input logic [7:0] base, input int n);
    chk($sformatf("%s_count", name), 32'(out_data.size()), 32'(n));
    for (int i = 0; i < out_data.size() && i < n; i++) begin
      chk($sformatf("%s_data%0d", name, i), 32'(out_data[i]), 32'(base + 8'(i)));
      chk($sformatf("%s_last%0d", name, i), 32'(out_last[i]), 32'(i == n - 1));
    end
  endtask

  initial begin
    rst     = 1'b1;
    r_ok    = 1'b0;
    rdata   = 8'h00;
    m_ready = 1'b0;
    upd_fifo();
    steps(2);

    chk("rst_r_en", 32'(r_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_burst_cnt", 32'(burst_cnt), 32'd0);
    rst = 1'b0;
    steps(2);

    // Full burst of 0..7 with no backpressure
    clear_logs();
    m_ready = 1'b1;
    load(8'h00, 8);
    steps(3);
    chk("full_busy_mid", 32'(busy), 32'd1);
    steps(17);
    chk("full_ren_count", 32'(ren_cyc.size()), 32'd8);
    if (ren_cyc.size() == 8 && out_cyc.size() == 8) begin
      chk("full_ren_span", 32'(ren_cyc[7] - ren_cyc[0]), 32'd7);
      chk("full_out_span", 32'(out_cyc[7] - out_cyc[0]), 32'd7);
      chk("full_latency", 32'(out_cyc[0] - ren_cyc[0]), 32'd2);
    end
    check_burst("full", 8'h00, 8);
    chk("full_burst_cnt", 32'(burst_cnt), 32'd1);
    chk("full_busy_end", 32'(busy), 32'd0);

    // Backpressure for 5 cycles mid-burst
    clear_logs();
    max_out = 0;
    load(8'h10, 8);
    steps(5);
    m_ready = 1'b0;
    steps(5);
    chk("bp_ren_stalled", 32'(last_ren), 32'd0);
    m_ready = 1'b1;
    steps(20);
    chk("bp_max_outstanding", 32'(max_out <= 2), 32'd1);
    chk("bp_ren_count", 32'(ren_cyc.size()), 32'd8);
    check_burst("bp", 8'h10, 8);
    chk("bp_burst_cnt", 32'(burst_cnt), 32'd2);

    // FIFO reports empty for 3 cycles mid-burst
    clear_logs();
    empty_viol = 0;
    load(8'h20, 8);
    steps(4);
    force_empty = 1'b1;
    upd_fifo();
    steps(3);
    force_empty = 1'b0;
    upd_fifo();
    steps(20);
    chk("uf_ren_while_empty", 32'(empty_viol), 32'd0);
    check_burst("uf", 8'h20, 8);
    chk("uf_burst_cnt", 32'(burst_cnt), 32'd3);

`ifndef FIFO_RD_BURST_TIMEOUT_EN
    // Below threshold: three words never drain
    clear_logs();
    busy_cyc = 0;
    load(8'h30, 3);
    steps(100);
    chk("thr_ren_count", 32'(ren_cyc.size()), 32'd0);
    chk("thr_busy_cycles", 32'(busy_cyc), 32'd0);
    chk("thr_burst_cnt", 32'(burst_cnt), 32'd3);
    rd_idx = wr_idx;
    upd_fifo();
    steps(2);
`else
    // Partial burst after 16 idle cycles
    clear_logs();
    load(8'h30, 3);
    begin
      int start_cyc;
      start_cyc = cyc;
      steps(40);
      chk("tmo_ren_count", 32'(ren_cyc.size()), 32'd3);
      if (ren_cyc.size() > 0) chk("tmo_first_ren", 32'(ren_cyc[0] - start_cyc), 32'd17);
    end
    check_burst("tmo", 8'h30, 3);
    chk("tmo_burst_cnt", 32'(burst_cnt), 32'd4);
`endif

    // Reset mid-burst
    clear_logs();
    load(8'h40, 8);
    steps(5);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_r_en", 32'(r_en), 32'd0);
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_m_last", 32'(m_last), 32'd0);
    chk("mid_rst_m_data", 32'(m_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_burst_cnt", 32'(burst_cnt), 32'd0);
    rd_idx = wr_idx;
    upd_fifo();
    step();
    r_ok  = 1'b1;
    rdata = 8'hEE;
    step();
    rst   = 1'b0;
    r_ok  = 1'b1;
    rdata = 8'hEF;
    clear_logs();
    steps(5);
    chk("post_rst_no_output", 32'(out_data.size()), 32'd0);
    chk("post_rst_m_valid", 32'(m_valid), 32'd0);
    chk("post_rst_burst_cnt", 32'(burst_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
